// File: rtl/mram_pkg.sv
// Shared definitions for the MRAM ternary write-verify controller.
// Contents: trit encodings, response status codes, controller state
// enumeration and a helper that checks a trit encoding is legal.
package mram_pkg;

   localparam logic [1:0] TRIT_0   = 2'b00;
   localparam logic [1:0] TRIT_1   = 2'b01;
   localparam logic [1:0] TRIT_2   = 2'b10;
   localparam logic [1:0] TRIT_BAD = 2'b11;

   typedef enum logic [1:0] {
      RSP_OK         = 2'b00,
      RSP_OK_RETRIED = 2'b01,
      RSP_FAIL       = 2'b10,
      RSP_BAD_ARG    = 2'b11
   } rsp_status_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_WAIT,
      S_SENSE,
      S_CHECK,
      S_RESP
   } state_t;

   function automatic logic trit_legal(input logic [1:0] t);
      return t != TRIT_BAD;
   endfunction

endpackage

// File: rtl/mram_write_verify_ctrl_if.sv
// Request/response bus of the write-verify controller.
// master: requester (drives req_valid/req_write/req_addr/req_trit, rsp_ready)
// slave : controller (drives req_ready, rsp_valid/rsp_trit/rsp_status/rsp_meta)
interface mram_write_verify_ctrl_if #(
   parameter int ADDR_BITS = 10
) ();

   logic                 req_valid;
   logic                 req_ready;
   logic                 req_write;
   logic [ADDR_BITS-1:0] req_addr;
   logic [1:0]           req_trit;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [1:0]           rsp_trit;
   logic [1:0]           rsp_status;
   logic                 rsp_meta;

   modport master (
      output req_valid, req_write, req_addr, req_trit, rsp_ready,
      input  req_ready, rsp_valid, rsp_trit, rsp_status, rsp_meta
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_trit, rsp_ready,
      output req_ready, rsp_valid, rsp_trit, rsp_status, rsp_meta
   );

endinterface

// File: rtl/mram_sat_counter.sv
// 8-bit saturating event counter.
// Ports: clk, rst (sync, active high), inc (count one event), count (value,
// sticks at 255).
module mram_sat_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   output logic [7:0] count
);

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (inc && count != 8'hFF)
         count <= count + 8'd1;
   end

endmodule

// File: rtl/mram_write_verify_ctrl.sv
// MRAM ternary-cell write-verify controller. Accepts read or write requests,
// pulses the write driver, waits for the pulse and settle time, senses the
// cell and rewrites up to MAX_RETRY times until the sensed trit matches and
// is outside the guard band.
// Ports: clk, rst (sync, active high); bus (request/response handshake);
// cell_addr/wr_en/wr_trit (write driver); sa_enable/sa_valid/sa_trit/sa_meta
// (sense amplifier); fail_count (saturating count of FAIL responses).
module mram_write_verify_ctrl
   import mram_pkg::*;
#(
   parameter int ADDR_BITS  = 10,
   parameter int MAX_RETRY  = 3,
   parameter int WR_CYC     = 3,
   parameter int SETTLE_CYC = 2,
   parameter int SA_TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   mram_write_verify_ctrl_if.slave bus,
   output logic [ADDR_BITS-1:0] cell_addr,
   output logic                 wr_en,
   output logic [1:0]           wr_trit,
   output logic                 sa_enable,
   input  logic                 sa_valid,
   input  logic [1:0]           sa_trit,
   input  logic                 sa_meta,
   output logic [7:0]           fail_count
);

   localparam int RETRY_W  = $clog2(MAX_RETRY + 1) + 2;
   localparam int WAIT_LEN = WR_CYC + SETTLE_CYC;
   localparam int WAIT_W   = $clog2(WAIT_LEN + 1);
   localparam int TO_W     = $clog2(SA_TIMEOUT + 1);

   state_t               state, nxt;
   logic                 is_write;
   logic [1:0]           target;
   logic [RETRY_W-1:0]   retry;
   logic [WAIT_W-1:0]    wait_cnt;
   logic [TO_W-1:0]      sense_cnt;
   logic [1:0]           cap_trit;
   logic                 cap_meta;
   logic [1:0]           rsp_trit_q;
   rsp_status_t          rsp_status_q;
   logic                 rsp_meta_q;

   logic accept, bad_arg, wait_done, sense_to, check_pass, retry_left, rsp_hs;

   assign accept     = (state == S_IDLE) && bus.req_valid;
   assign bad_arg    = bus.req_write && !trit_legal(bus.req_trit);
   assign wait_done  = wait_cnt == WAIT_W'(WAIT_LEN - 1);
   assign sense_to   = sense_cnt == TO_W'(SA_TIMEOUT - 1);
   assign check_pass = (cap_trit == target) && !cap_meta;
   assign retry_left = retry < RETRY_W'(MAX_RETRY);
   assign rsp_hs     = (state == S_RESP) && bus.rsp_ready;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= nxt;
   end

   // next state
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:
            if (accept) begin
               if (!bus.req_write) nxt = S_SENSE;
               else if (bad_arg)   nxt = S_RESP;
               else                nxt = S_WRITE;
            end
         S_WRITE: nxt = S_WAIT;
         S_WAIT:  if (wait_done) nxt = S_SENSE;
         S_SENSE:
            if (sa_valid)      nxt = is_write ? S_CHECK : S_RESP;
            else if (sense_to) nxt = S_RESP;
         S_CHECK:
            if (check_pass || !retry_left) nxt = S_RESP;
            else                           nxt = S_WRITE;
         S_RESP:  if (bus.rsp_ready) nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   // outputs decoded from state; response fields come from registers so
   // they stay frozen for as long as RESP waits on rsp_ready
   always_comb begin
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      wr_en         = 1'b0;
      sa_enable     = 1'b0;
      case (state)
         S_IDLE:  bus.req_ready = 1'b1;
         S_WRITE: wr_en         = 1'b1;
         S_SENSE: sa_enable     = 1'b1;
         S_RESP:  bus.rsp_valid = 1'b1;
         default: ;
      endcase
   end

   assign bus.rsp_trit   = rsp_trit_q;
   assign bus.rsp_status = rsp_status_q;
   assign bus.rsp_meta   = rsp_meta_q;
   assign wr_trit        = target;

   // datapath: request latch, cycle counters, sense capture, response build
   always_ff @(posedge clk) begin
      if (rst) begin
         cell_addr    <= '0;
         is_write     <= 1'b0;
         target       <= TRIT_0;
         retry        <= '0;
         wait_cnt     <= '0;
         sense_cnt    <= '0;
         cap_trit     <= TRIT_0;
         cap_meta     <= 1'b0;
         rsp_trit_q   <= TRIT_0;
         rsp_status_q <= RSP_OK;
         rsp_meta_q   <= 1'b0;
      end else begin
         wait_cnt  <= (state == S_WAIT)  ? wait_cnt + WAIT_W'(1) : '0;
         sense_cnt <= (state == S_SENSE) ? sense_cnt + TO_W'(1)  : '0;
         case (state)
            S_IDLE:
               if (accept) begin
                  cell_addr <= bus.req_addr;
                  target    <= bus.req_trit;
                  is_write  <= bus.req_write;
                  retry     <= '0;
                  if (bad_arg) begin
                     rsp_trit_q   <= TRIT_0;
                     rsp_status_q <= RSP_BAD_ARG;
                     rsp_meta_q   <= 1'b0;
                  end
               end
            S_SENSE:
               if (sa_valid) begin
                  cap_trit <= sa_trit;
                  cap_meta <= sa_meta;
                  // reads bypass CHECK, so the response is built here
                  if (!is_write) begin
                     rsp_trit_q   <= sa_trit;
                     rsp_status_q <= RSP_OK;
                     rsp_meta_q   <= sa_meta;
                  end
               end else if (sense_to) begin
                  rsp_trit_q   <= TRIT_0;
                  rsp_status_q <= RSP_FAIL;
                  rsp_meta_q   <= 1'b0;
               end
            S_CHECK:
               if (check_pass) begin
                  rsp_trit_q   <= cap_trit;
                  rsp_status_q <= (retry == '0) ? RSP_OK : RSP_OK_RETRIED;
                  rsp_meta_q   <= 1'b0;
               end else if (retry_left) begin
                  retry <= retry + RETRY_W'(1);
               end else begin
                  rsp_trit_q   <= cap_trit;
                  rsp_status_q <= RSP_FAIL;
                  rsp_meta_q   <= cap_meta;
               end
            default: ;
         endcase
      end
   end

   mram_sat_counter u_fail_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (rsp_hs && rsp_status_q == RSP_FAIL),
      .count (fail_count)
   );

endmodule
